dmem_lane_arbiter: RTL and testbench

- Shared controller for the four 8-bit x 16K data-RAM byte lanes (lane k holds byte k of each 32-bit word); 64 KiB data space.
- Arbitrates two requesters, port 0 = core LSU and port 1 = program loader/debug, with round-robin grants.
- Decodes RV32 load/store size (funct3) into per-lane word addresses, write enables and byte steering; sign/zero-extends load data.
- Lanes read asynchronously; the block registers the response.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_steer.sv | 91 +++++++++
 rtl/dmem_lane_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_lane_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory lane arbiter: funct3 size codes,
// FSM state encoding and lane geometry.
package dmem_pkg;

  localparam int LANE_AW = 14;  // word address bits per byte lane (16384 entries)
  localparam int NLANE   = 4;   // byte lanes per 32-bit word

  // RV32 load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational size/offset decode for one 32-bit data access spread over
// four byte lanes: lane addresses, write enables, write bytes, load-data
// assembly with sign/zero extension, and the error flag.
// Macro DMEM_MISALIGN_EN: when defined, misaligned H/W accesses are legal and
// split across two word rows; otherwise they are flagged as errors.
module dmem_lane_steer
  import dmem_pkg::*;
(
  input  logic                            we,
  input  logic [2:0]                      funct3,
  input  logic [15:0]                     addr,
  input  logic [31:0]                     wdata,
  input  logic [NLANE-1:0][7:0]           lane_rdata,
  output logic [NLANE-1:0][LANE_AW-1:0]   lane_addr,
  output logic [NLANE-1:0]                lane_wren,
  output logic [NLANE-1:0][7:0]           lane_wdata,
  output logic [31:0]                     rdata,
  output logic                            err
);

  logic [LANE_AW-1:0]      word;
  logic [1:0]              off;
  logic [2:0]              nbytes;
  logic                    legal;
  logic                    misalign;
  logic [NLANE-1:0][1:0]   idx;      // access byte index carried by each lane
  logic [NLANE-1:0]        touched;
  logic [31:0]             raw;

  assign word = addr[15:2];
  assign off  = addr[1:0];

  // Size decode; unsigned variants are load-only.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    nbytes = 3'd0;
    legal  = 1'b0;
    case (funct3)
      F3_B:    begin nbytes = 3'd1; legal = 1'b1; end
      F3_H:    begin nbytes = 3'd2; legal = 1'b1; end
      F3_W:    begin nbytes = 3'd4; legal = 1'b1; end
      F3_BU:   begin nbytes = 3'd1; legal = !we;  end
      F3_HU:   begin nbytes = 3'd2; legal = !we;  end
      default: begin nbytes = 3'd0; legal = 1'b0; end
    endcase
  end

`ifdef DMEM_MISALIGN_EN
  assign misalign = 1'b0;
`else
  assign misalign = ((nbytes == 3'd2) && (off == 2'd3)) ||
                    ((nbytes == 3'd4) && (off != 2'd0));
`endif

  assign err = !legal || misalign;

  // Per-lane steering: lane l carries access byte (l - off) mod 4; lanes below
  // the offset belong to the next word row (wrapping 16383 -> 0).
  always_comb begin
    idx        = '0;
    touched    = '0;
    lane_addr  = '0;
    lane_wren  = '0;
    lane_wdata = '0;
    raw        = '0;
    for (int l = 0; l < NLANE; l++) begin
      idx[l]        = 2'(l) - off;
      touched[l]    = ({1'b0, idx[l]} < nbytes);
      lane_addr[l]  = (touched[l] && (2'(l) < off)) ? word + LANE_AW'(1) : word;
      lane_wren[l]  = we && touched[l] && !err;
      lane_wdata[l] = wdata[8*idx[l] +: 8];
      raw[8*idx[l] +: 8] = lane_rdata[l];
    end
  end

  // Load extension; stores and errors return zero.
  always_comb begin
    rdata = '0;
    if (!we && !err) begin
      case (funct3)
        F3_B:    rdata = {{24{raw[7]}},  raw[7:0]};
        F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
        F3_BU:   rdata = {24'b0, raw[7:0]};
        F3_HU:   rdata = {16'b0, raw[15:0]};
        default: rdata = raw;
      endcase
    end
  end

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the four byte-lane
// data RAMs (64 KiB). One transaction every three cycles:
// IDLE (handshake) -> ACCESS (lanes driven, response captured) -> RESP (strobe).
// Macro DMEM_MISALIGN_EN (handled in dmem_lane_steer) enables misaligned H/W.
module dmem_lane_arbiter #(
  parameter int LANE_AW = dmem_pkg::LANE_AW,
  parameter int NPORT   = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NPORT-1:0]                        m_valid_i,
  output logic [NPORT-1:0]                        m_ready_o,
  input  logic [NPORT-1:0]                        m_we_i,
  input  logic [NPORT-1:0][2:0]                   m_funct3_i,
  input  logic [NPORT-1:0][31:0]                  m_addr_i,
  input  logic [NPORT-1:0][31:0]                  m_wdata_i,
  output logic [NPORT-1:0]                        m_rsp_valid_o,
  output logic [31:0]                             rsp_rdata_o,
  output logic                                    rsp_err_o,
  output logic [dmem_pkg::NLANE-1:0][LANE_AW-1:0] lane_addr_o,
  output logic [dmem_pkg::NLANE-1:0]              lane_wren_o,
  output logic [dmem_pkg::NLANE-1:0][7:0]         lane_wdata_o,
  input  logic [dmem_pkg::NLANE-1:0][7:0]         lane_rdata_i
);

  import dmem_pkg::*;

  state_e       state;
  logic         last_grant;
  logic         owner;
  logic         grant;
  logic         req_we;
  logic [2:0]   req_funct3;
  logic [15:0]  req_addr;
  logic [31:0]  req_wdata;

  logic [NLANE-1:0]  st_wren;
  logic [31:0]       st_rdata;
  logic              st_err;
  logic              unused_addr_hi;

  // Upper address bits lie outside the 64 KiB window and are ignored.
  assign unused_addr_hi = ^{m_addr_i[0][31:16], m_addr_i[1][31:16]};

  // Round-robin pick: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    grant = 1'b0;
    if (m_valid_i[0] && m_valid_i[1]) grant = ~last_grant;
    else if (m_valid_i[1])            grant = 1'b1;
  end

  assign m_ready_o = ((state == ST_IDLE) && !rst_i)
                     ? (m_valid_i & (NPORT'(1) << grant)) : '0;

  dmem_lane_steer u_steer (
    .we         (req_we),
    .funct3     (req_funct3),
    .addr       (req_addr),
    .wdata      (req_wdata),
    .lane_rdata (lane_rdata_i),
    .lane_addr  (lane_addr_o),
    .lane_wren  (st_wren),
    .lane_wdata (lane_wdata_o),
    .rdata      (st_rdata),
    .err        (st_err)
  );

  // Writes reach the lanes only during the single ACCESS cycle.
  assign lane_wren_o = (state == ST_ACCESS) ? st_wren : '0;

  // Sequencer: latch the granted request, run the access, strobe the owner.
  always_ff @(posedge clk_i) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      req_we        <= 1'b0;
      req_funct3    <= '0;
      req_addr      <= '0;
      req_wdata     <= '0;
      m_rsp_valid_o <= '0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_ready_o) begin
            req_we     <= m_we_i[grant];
            req_funct3 <= m_funct3_i[grant];
            req_addr   <= m_addr_i[grant][15:0];
            req_wdata  <= m_wdata_i[grant];
            last_grant <= grant;
            owner      <= grant;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rsp_rdata_o   <= st_rdata;
          rsp_err_o     <= st_err;
          m_rsp_valid_o <= NPORT'(1) << owner;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          m_rsp_valid_o <= '0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Self-checking bench for dmem_lane_arbiter: byte-addressed reference memory,
// per-lane RAM models, arbiter grant model and an expected-response queue.
module tb_dmem_lane_arbiter;
  import dmem_pkg::*;

  logic                    clk_i;
  logic                    rst_i;
  logic [1:0]              m_valid_i;
  logic [1:0]              m_ready_o;
  logic [1:0]              m_we_i;
  logic [1:0][2:0]         m_funct3_i;
  logic [1:0][31:0]        m_addr_i;
  logic [1:0][31:0]        m_wdata_i;
  logic [1:0]              m_rsp_valid_o;
  logic [31:0]             rsp_rdata_o;
  logic                    rsp_err_o;
  logic [3:0][13:0]        lane_addr_o;
  logic [3:0]              lane_wren_o;
  logic [3:0][7:0]         lane_wdata_o;
  logic [3:0][7:0]         lane_rdata_i;

  // per-port driver state
  logic        tb_valid [2];
  logic        tb_we    [2];
  logic [2:0]  tb_f3    [2];
  logic [31:0] tb_addr  [2];
  logic [31:0] tb_wdata [2];

  assign m_valid_i  = {tb_valid[1], tb_valid[0]};
  assign m_we_i     = {tb_we[1], tb_we[0]};
  assign m_funct3_i = {tb_f3[1], tb_f3[0]};
  assign m_addr_i   = {tb_addr[1], tb_addr[0]};
  assign m_wdata_i  = {tb_wdata[1], tb_wdata[0]};

  dmem_lane_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m_valid_i     (m_valid_i),
    .m_ready_o     (m_ready_o),
    .m_we_i        (m_we_i),
    .m_funct3_i    (m_funct3_i),
    .m_addr_i      (m_addr_i),
    .m_wdata_i     (m_wdata_i),
    .m_rsp_valid_o (m_rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .lane_addr_o   (lane_addr_o),
    .lane_wren_o   (lane_wren_o),
    .lane_wdata_o  (lane_wdata_o),
    .lane_rdata_i  (lane_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Lane RAMs: async read, write on rising edge.
  logic [7:0] lane_mem [4][16384];
  logic [7:0] ref_mem  [65536];

  always_comb begin
    for (int l = 0; l < 4; l++) lane_rdata_i[l] = lane_mem[l][lane_addr_o[l]];
  end

  always @(posedge clk_i) begin
    for (int l = 0; l < 4; l++)
      if (lane_wren_o[l]) lane_mem[l][lane_addr_o[l]] <= lane_wdata_o[l];
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] rd;
    logic        err;
    logic [3:0]  wren;
  } exp_t;

  exp_t q[$];

  // Byte-level reference for one access; updates ref_mem for stores.
  function automatic exp_t model(input logic p, input logic we, input logic [2:0] f3,
                                 input logic [15:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    logic [31:0] raw;
    logic [15:0] bi;
    e.port = p; e.rd = '0; e.err = 1'b0; e.wren = '0; raw = '0;
    case (f3)
      3'b000:  n = 1;
      3'b001:  n = 2;
      3'b010:  n = 4;
      3'b100:  n = we ? 0 : 1;
      3'b101:  n = we ? 0 : 2;
      default: n = 0;
    endcase
    if (n == 0) e.err = 1'b1;
`ifndef DMEM_MISALIGN_EN
    if ((n == 2 && a[1:0] == 2'd3) || (n == 4 && a[1:0] != 2'd0)) e.err = 1'b1;
`endif
    if (!e.err) begin
      for (int i = 0; i < n; i++) begin
        bi = a + 16'(i);
        if (we) begin
          ref_mem[bi] = wd[8*i +: 8];
          e.wren[bi[1:0]] = 1'b1;
        end else begin
          raw[8*i +: 8] = ref_mem[bi];
        end
      end
      if (!we) begin
        case (f3)
          3'b000:  e.rd = {{24{raw[7]}}, raw[7:0]};
          3'b001:  e.rd = {{16{raw[15]}}, raw[15:0]};
          3'b100:  e.rd = {24'b0, raw[7:0]};
          3'b101:  e.rd = {16'b0, raw[15:0]};
          default: e.rd = raw;
        endcase
      end
    end
    return e;
  endfunction

  // Monitor: tracks the expected FSM phase, checks ready/grant every IDLE
  // cycle, wren in ACCESS and the response in RESP.
  int         ph = 0;
  logic       mon_en = 1'b0;
  logic       exp_last = 1'b1;
  logic       mg;
  logic [1:0] mrdy;
  logic [1:0] moh;
  exp_t       me;

  always @(negedge clk_i) begin
    if (mon_en) begin
      case (ph)
        0: begin
          mg = (m_valid_i == 2'b11) ? ~exp_last : m_valid_i[1];
          mrdy = rst_i ? 2'b00 : (m_valid_i & (mg ? 2'b10 : 2'b01));
          check("ready_idle", {30'b0, m_ready_o}, {30'b0, mrdy});
          check("rsp_quiet", {30'b0, m_rsp_valid_o}, 32'd0);
          if (mrdy != 2'b00) begin
            me = model(mg, tb_we[mg], tb_f3[mg], tb_addr[mg][15:0], tb_wdata[mg]);
            q.push_back(me);
            exp_last = mg;
            ph = 1;
          end
        end
        1: begin
          check("ready_access", {30'b0, m_ready_o}, 32'd0);
          check("rsp_access", {30'b0, m_rsp_valid_o}, 32'd0);
          check("wren_access", {28'b0, lane_wren_o}, {28'b0, q[0].wren});
          ph = 2;
        end
        default: begin
          moh = q[0].port ? 2'b10 : 2'b01;
          check("ready_resp", {30'b0, m_ready_o}, 32'd0);
          check("rsp_strobe", {30'b0, m_rsp_valid_o}, {30'b0, moh});
          check("rsp_rdata", rsp_rdata_o, q[0].rd);
          check("rsp_err", {31'b0, rsp_err_o}, {31'b0, q[0].err});
          check("wren_resp", {28'b0, lane_wren_o}, 32'd0);
          void'(q.pop_front());
          ph = 0;
        end
      endcase
      if (rst_i) begin
        ph = 0;
        q.delete();
        exp_last = 1'b1;
      end
    end
  end

  // Drive one request on port p; returns at posedge+1 after the handshake.
  task automatic req(input int p, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    int   n;
    logic hs;
    tb_we[p] = we; tb_f3[p] = f3; tb_addr[p] = a; tb_wdata[p] = wd;
    tb_valid[p] = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 60) begin
      @(negedge clk_i);
      hs = m_ready_o[p] && !rst_i;
      n++;
      @(posedge clk_i); #1;
    end
    tb_valid[p] = 1'b0;
    if (!hs) check("req_timeout", {31'b0, hs}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ph != 0) && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0]  b;
  logic [7:0]  old3, old0;
  logic [31:0] ra;
  logic [2:0]  ld_f3 [4];

  initial begin
    for (int a = 0; a < 65536; a++) begin
      b = 8'($urandom());
      ref_mem[a] = b;
      lane_mem[a % 4][a / 4] = b;
    end
    for (int p = 0; p < 2; p++) begin
      tb_valid[p] = 1'b0; tb_we[p] = 1'b0; tb_f3[p] = '0;
      tb_addr[p] = '0; tb_wdata[p] = '0;
    end
    ld_f3[0] = F3_W; ld_f3[1] = F3_B; ld_f3[2] = F3_HU; ld_f3[3] = F3_BU;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    // reset values
    check("rst_rsp_valid", {30'b0, m_rsp_valid_o}, 32'd0);
    check("rst_ready", {30'b0, m_ready_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_err", {31'b0, rsp_err_o}, 32'd0);
    check("rst_wren", {28'b0, lane_wren_o}, 32'd0);
    check("rst_wdata", lane_wdata_o, 32'd0);
    for (int l = 0; l < 4; l++) check("rst_lane_addr", {18'b0, lane_addr_o[l]}, 32'd0);
    mon_en = 1'b1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // word store then loads of various sizes
    req(0, 1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF);
    drain();
    check("lane0_w4", {24'b0, lane_mem[0][4]}, 32'h0000_00EF);
    check("lane1_w4", {24'b0, lane_mem[1][4]}, 32'h0000_00BE);
    check("lane2_w4", {24'b0, lane_mem[2][4]}, 32'h0000_00AD);
    check("lane3_w4", {24'b0, lane_mem[3][4]}, 32'h0000_00DE);
    req(0, 1'b0, F3_W,  32'h0000_0010, 32'h0);
    req(0, 1'b0, F3_B,  32'h0000_0013, 32'h0);
    req(0, 1'b0, F3_BU, 32'h0000_0013, 32'h0);
    req(0, 1'b0, F3_H,  32'h0000_0012, 32'h0);
    req(1, 1'b0, F3_HU, 32'hABCD_0012, 32'h0);
    drain();

    // both ports valid from reset: alternating grants
    rst_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) req(0, 1'b0, ld_f3[i], 32'h0000_0010 + 32'(4*i), 32'h0);
      end
      begin
        for (int i = 0; i < 4; i++) req(1, 1'b0, ld_f3[3-i], 32'h0000_0100 + 32'(i), 32'h0);
      end
      begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
      end
    join
    drain();

    // halfword across the top of memory
    old3 = lane_mem[3][16383];
    old0 = lane_mem[0][0];
    req(0, 1'b1, F3_H, 32'h0000_FFFF, 32'h0000_1234);
    drain();
`ifdef DMEM_MISALIGN_EN
    check("wrap_lane3", {24'b0, lane_mem[3][16383]}, 32'h0000_0034);
    check("wrap_lane0", {24'b0, lane_mem[0][0]}, 32'h0000_0012);
`else
    check("wrap_lane3", {24'b0, lane_mem[3][16383]}, {24'b0, old3});
    check("wrap_lane0", {24'b0, lane_mem[0][0]}, {24'b0, old0});
`endif
    req(1, 1'b0, F3_HU, 32'h0000_FFFF, 32'h0);
    req(0, 1'b1, F3_W,  32'h0000_1006, 32'h8765_4321);
    req(0, 1'b0, F3_W,  32'h0000_1006, 32'h0);
    req(1, 1'b0, F3_W,  32'h0000_1004, 32'h0);
    req(1, 1'b0, F3_W,  32'h0000_1008, 32'h0);
    req(0, 1'b0, F3_H,  32'h0000_1007, 32'h0);

    // illegal encodings
    req(0, 1'b0, 3'b011, 32'h0000_0010, 32'h0);
    req(1, 1'b1, 3'b100, 32'h0000_0010, 32'hFFFF_FFFF);
    req(0, 1'b1, 3'b101, 32'h0000_0010, 32'hFFFF_FFFF);
    req(1, 1'b0, 3'b110, 32'h0000_0010, 32'h0);
    req(0, 1'b1, 3'b111, 32'h0000_0010, 32'hFFFF_FFFF);
    drain();

    // reset during ACCESS of a store: write lands, response dropped
    req(0, 1'b1, F3_W, 32'h0000_0020, 32'hCAFE_F00D);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req(1, 1'b0, F3_W, 32'h0000_0020, 32'h0);
    drain();

    // random mix near both ends of the address space
    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      ra[15:0] = ($urandom_range(0, 1) == 1) ? (16'hFFC0 | 16'(ra[5:0])) : 16'(ra[5:0]);
      req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), ra, $urandom());
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
